// File: rtl/simd_shifter_pkg.sv
// Shared types for the SIMD shifter datapath and its requester scheduler.
package simd_shifter_pkg;

    typedef logic [63:0] word_t;
    typedef logic [5:0]  shift_t;

    // Lane width selector: 8 x 8b, 4 x 16b, 2 x 32b or 1 x 64b lanes.
    typedef enum logic [1:0] {
        MODE_8  = 2'd0,
        MODE_16 = 2'd1,
        MODE_32 = 2'd2,
        MODE_64 = 2'd3
    } mode_t;

    // Per-lane operation: logical left/right, arithmetic right, rotate left.
    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROL = 2'd3
    } op_t;

    localparam int SIMD_SHIFTER_SCHED_N_REQ = 4;

    // Operand bundle captured by the scheduler's issue stage.
    typedef struct packed {
        word_t              in;
        mode_t              mode;
        op_t                op;
        shift_t [7:0]       shift;
    } sched_payload_t;

endpackage

// File: rtl/simd_shifter.sv
// Combinational SIMD shifter: each lane shifts by its own amount, taken
// modulo the lane width; lanes never exchange bits.
module simd_shifter
    import simd_shifter_pkg::*;
(
    input  word_t        in,
    input  mode_t        mode,
    input  op_t          op,
    input  shift_t [7:0] shift,
    output word_t        out
);

    // One lane of width w held in the low bits of x; result is masked to w bits.
    function automatic word_t lane_op(input word_t x, input int unsigned w,
                                      input shift_t amt_raw, input op_t f);
        word_t  mask;
        word_t  sx;
        word_t  r;
        shift_t amt;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        amt  = amt_raw & shift_t'(w - 1);
        sx   = x[6'(w - 1)] ? (x | ~mask) : (x & mask);
        unique case (f)
            OP_SLL:  r = x << amt;
            OP_SRL:  r = (x & mask) >> amt;
            OP_SRA:  r = $signed(sx) >>> amt;
            default: r = (x << amt) | ((x & mask) >> (w - int'(amt)));
        endcase
        return r & mask;
    endfunction

    word_t r8, r16, r32, r64;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_l8
            assign r8[gi*8 +: 8] = 8'(lane_op(64'(in[gi*8 +: 8]), 8, shift[gi], op));
        end
        for (gi = 0; gi < 4; gi++) begin : g_l16
            assign r16[gi*16 +: 16] = 16'(lane_op(64'(in[gi*16 +: 16]), 16, shift[gi], op));
        end
        for (gi = 0; gi < 2; gi++) begin : g_l32
            assign r32[gi*32 +: 32] = 32'(lane_op(64'(in[gi*32 +: 32]), 32, shift[gi], op));
        end
        for (gi = 0; gi < 1; gi++) begin : g_l64
            assign r64 = lane_op(in, 64, shift[gi], op);
        end
    endgenerate

    // Select the lane layout requested by mode.
    always_comb begin
        out = r64;
        unique case (mode)
            MODE_8:  out = r8;
            MODE_16: out = r16;
            MODE_32: out = r32;
            default: out = r64;
        endcase
    end

endmodule

// File: rtl/simd_shifter_rr_arb.sv
// Combinational round-robin arbiter; the priority pointer lives in the parent
// so it only moves when a grant is actually accepted.
module simd_shifter_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    // Search from ptr+1 upward, wrapping, and take the first active request.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simd_shifter_sched.sv
// Shares one simd_shifter between N_REQ requesters: round-robin issue into S1,
// shift, register result and owner id in S2. Note req_ready depends
// combinationally on rsp_ready through the stage-advance logic.
module simd_shifter_sched
    import simd_shifter_pkg::*;
#(
    parameter  int N_REQ = SIMD_SHIFTER_SCHED_N_REQ,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  word_t  [N_REQ-1:0]     req_in,
    input  mode_t  [N_REQ-1:0]     req_mode,
    input  op_t    [N_REQ-1:0]     req_op,
    input  shift_t [N_REQ-1:0][7:0] req_shift,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output word_t                  rsp_out,
    output logic [ID_W-1:0]        rsp_id
);

    logic            s1_v_reg, s2_v_reg;
    sched_payload_t  s1_pay_reg, load_pay;
    logic [ID_W-1:0] s1_id_reg, s2_id_reg, ptr_reg;
    word_t           s2_out_reg, shift_out;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_any, s2_adv, s1_free, req_hs;

    simd_shifter_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    simd_shifter u_shifter (
        .in    (s1_pay_reg.in),
        .mode  (s1_pay_reg.mode),
        .op    (s1_pay_reg.op),
        .shift (s1_pay_reg.shift),
        .out   (shift_out)
    );

    // S2 takes S1 when empty or draining; S1 accepts when empty or moving on.
    // req_ready is forced low while reset is asserted.
    assign s2_adv    = s1_v_reg & (~s2_v_reg | rsp_ready);
    assign s1_free   = ~s1_v_reg | s2_adv;
    assign req_ready = grant & {N_REQ{s1_free & rst_n}};
    assign req_hs    = grant_any & s1_free;

    // Gather the granted requester's operands.
    always_comb begin
        load_pay       = '0;
        load_pay.in    = req_in[grant_id];
        load_pay.mode  = req_mode[grant_id];
        load_pay.op    = req_op[grant_id];
        load_pay.shift = req_shift[grant_id];
    end

    // Issue stage and priority pointer; pointer moves only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg   <= 1'b0;
            s1_pay_reg <= '0;
            s1_id_reg  <= '0;
            ptr_reg    <= ID_W'(N_REQ - 1);
        end else if (req_hs) begin
            s1_v_reg   <= 1'b1;
            s1_pay_reg <= load_pay;
            s1_id_reg  <= grant_id;
            ptr_reg    <= grant_id;
        end else if (s2_adv) begin
            s1_v_reg   <= 1'b0;
        end
    end

    // Output stage; data holds whenever nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg   <= 1'b0;
            s2_out_reg <= '0;
            s2_id_reg  <= '0;
        end else if (s2_adv) begin
            s2_v_reg   <= 1'b1;
            s2_out_reg <= shift_out;
            s2_id_reg  <= s1_id_reg;
        end else if (rsp_ready) begin
            s2_v_reg   <= 1'b0;
        end
    end

    assign rsp_valid = s2_v_reg;
    assign rsp_out   = s2_out_reg;
    assign rsp_id    = s2_id_reg;

endmodule

// File: tb/tb_simd_shifter_sched.sv
// Self-checking bench for simd_shifter_sched: directed scenarios plus a long
// randomized run against a transaction-level model (in-order queue, abstract
// occupancy, bit-level lane shifter).
module tb_simd_shifter_sched;
    import simd_shifter_pkg::*;

    localparam int N_REQ = 4;

    logic                     clk;
    logic                     rst_n;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    word_t  [N_REQ-1:0]       req_in;
    mode_t  [N_REQ-1:0]       req_mode;
    op_t    [N_REQ-1:0]       req_op;
    shift_t [N_REQ-1:0][7:0]  req_shift;
    logic                     rsp_valid;
    logic                     rsp_ready;
    word_t                    rsp_out;
    logic [1:0]               rsp_id;

    simd_shifter_sched #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in    (req_in),
        .req_mode  (req_mode),
        .req_op    (req_op),
        .req_shift (req_shift),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    // Bit-level reference of the lane shifter.
    function automatic word_t model_shift(input word_t v, input mode_t m, input op_t f,
                                          input shift_t [7:0] sh);
        word_t res;
        int w, lanes, amt, src;
        res   = '0;
        w     = 8 << int'(m);
        lanes = 64 / w;
        for (int l = 0; l < lanes; l++) begin
            amt = int'(sh[l]) % w;
            for (int b = 0; b < w; b++) begin
                case (f)
                    OP_SLL: res[l*w+b] = (b >= amt) ? v[l*w+b-amt] : 1'b0;
                    OP_SRL: res[l*w+b] = (b + amt < w) ? v[l*w+b+amt] : 1'b0;
                    OP_SRA: res[l*w+b] = (b + amt < w) ? v[l*w+b+amt] : v[l*w+w-1];
                    default: begin
                        src = (b - amt + w) % w;
                        res[l*w+b] = v[l*w+src];
                    end
                endcase
            end
        end
        return res;
    endfunction

    typedef struct {
        int    cyc;
        int    id;
        word_t out;
    } exp_t;

    exp_t             exp_q[$];
    int               grant_log[$];
    int               rsp_log[$];
    int               cyc = 0;
    int               ptr_m = N_REQ - 1;
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] hs_vec = '0;
    logic             exp_v;
    int               idx;

    // Monitor: runs at every falling edge, predicts the upcoming rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            ptr_m  = N_REQ - 1;
            hs_vec = '0;
        end else begin
            exp_ready = '0;
            if (exp_q.size() < 2 || rsp_ready) begin
                for (int off = 1; off <= N_REQ; off++) begin
                    idx = (ptr_m + off) % N_REQ;
                    if (exp_ready == '0 && req_valid[idx]) exp_ready[idx] = 1'b1;
                end
            end
            check_val("req_ready", 64'(req_ready), 64'(exp_ready));
            exp_v = 1'b0;
            if (exp_q.size() > 0) exp_v = (cyc >= exp_q[0].cyc + 2);
            check_val("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (exp_v) begin
                check_val("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                check_val("rsp_out", rsp_out, exp_q[0].out);
                if (rsp_ready) begin
                    rsp_log.push_back(int'(rsp_id));
                    void'(exp_q.pop_front());
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (exp_ready[i]) begin
                    exp_q.push_back('{cyc, i, model_shift(req_in[i], req_mode[i], req_op[i], req_shift[i])});
                    ptr_m = i;
                    grant_log.push_back(i);
                end
            end
            hs_vec = req_valid & req_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input int i);
        req_in[i]   = {$urandom(), $urandom()};
        req_mode[i] = mode_t'($urandom_range(0, 3));
        req_op[i]   = op_t'($urandom_range(0, 3));
        for (int l = 0; l < 8; l++) req_shift[i][l] = shift_t'($urandom_range(0, 63));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) rand_payload(i);

        // Reset state, with requests pending to show they are not accepted.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_out", rsp_out, 64'd0);
        check_val("rst_rsp_id", 64'(rsp_id), 64'd0);
        check_val("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        step();

        // Single request from requester 2: 1 << 4 in 64-bit mode.
        req_in[2]   = 64'h1;
        req_mode[2] = MODE_64;
        req_op[2]   = OP_SLL;
        for (int l = 0; l < 8; l++) req_shift[2][l] = '0;
        req_shift[2][0] = 6'd4;
        req_valid = 4'b0100;
        @(negedge clk);
        check_val("single_grant", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check_val("single_not_yet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_val("single_valid", 64'(rsp_valid), 64'd1);
        check_val("single_out", rsp_out, 64'h10);
        check_val("single_id", 64'(rsp_id), 64'd2);
        @(negedge clk);
        check_val("single_done", 64'(rsp_valid), 64'd0);
        step();

        // Fairness: all requesters valid after reset.
        do_reset();
        clear_logs();
        for (int i = 0; i < N_REQ; i++) rand_payload(i);
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        repeat (4) step();
        check_val("rr_grant_cnt", 64'(grant_log.size()), 64'd8);
        check_val("rr_rsp_cnt", 64'(rsp_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size() && i < rsp_log.size(); i++) begin
            check_val("rr_grant_order", 64'(grant_log[i]), 64'(i % 4));
            check_val("rr_rsp_order", 64'(rsp_log[i]), 64'(i % 4));
        end

        // Backpressure with requesters 0 and 1.
        do_reset();
        clear_logs();
        rsp_ready = 1'b0;
        rand_payload(0);
        rand_payload(1);
        req_valid = 4'b0011;
        repeat (4) step();
        @(negedge clk);
        check_val("bp_blocked", 64'(req_ready), 64'd0);
        check_val("bp_hold_valid", 64'(rsp_valid), 64'd1);
        check_val("bp_hold_id", 64'(rsp_id), 64'd0);
        step();
        check_val("bp_hs_cnt", 64'(grant_log.size()), 64'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_refill", 64'(req_ready), 64'b0001);
        check_val("bp_first_id", 64'(rsp_id), 64'd0);
        step();
        req_valid = '0;
        @(negedge clk);
        check_val("bp_second_valid", 64'(rsp_valid), 64'd1);
        check_val("bp_second_id", 64'(rsp_id), 64'd1);
        repeat (4) step();
        check_val("bp_rsp_cnt", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            check_val("bp_rsp0", 64'(rsp_log[0]), 64'd0);
            check_val("bp_rsp1", 64'(rsp_log[1]), 64'd1);
            check_val("bp_rsp2", 64'(rsp_log[2]), 64'd0);
        end

        // Sparse: 3 alone, then 1 arrives while 3 still asks.
        clear_logs();
        rand_payload(3);
        rand_payload(1);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1010;
        step();
        req_valid = '0;
        repeat (4) step();
        check_val("sp_cnt", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2 && rsp_log.size() == 2) begin
            check_val("sp_g0", 64'(grant_log[0]), 64'd3);
            check_val("sp_g1", 64'(grant_log[1]), 64'd1);
            check_val("sp_r0", 64'(rsp_log[0]), 64'd3);
            check_val("sp_r1", 64'(rsp_log[1]), 64'd1);
        end

        // Reset while both stages hold data.
        rsp_ready = 1'b0;
        rand_payload(2);
        rand_payload(3);
        req_valid = 4'b1100;
        repeat (3) step();
        @(negedge clk);
        check_val("mr_pre_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("mr_req_ready", 64'(req_ready), 64'd0);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) rand_payload(i);
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        req_valid = '0;
        repeat (4) step();
        check_val("mr_cnt", 64'(rsp_log.size()), 64'd1);
        if (grant_log.size() > 0 && rsp_log.size() > 0) begin
            check_val("mr_first_grant", 64'(grant_log[0]), 64'd0);
            check_val("mr_first_rsp", 64'(rsp_log[0]), 64'd0);
        end

        // Randomized traffic: payload held until accepted, then re-rolled.
        for (int c = 0; c < 12000; c++) begin
            step();
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || hs_vec[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    rand_payload(i);
                end
            end
        end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) step();
        check_val("drain_idle", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simd_shifter_sched.md
Name: simd_shifter_sched

Overview:
- Shares one combinational `simd_shifter` datapath between N_REQ independent requesters.
- Round-robin arbitration over valid/ready request channels.
- Operands are registered into an issue stage, shifted, and the result plus requester ID is registered into an output stage with a valid/ready response channel.
- Sits between the lane-issue logic and the writeback/result bus; full throughput of one shift per cycle under no backpressure.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(N_REQ), derived width of the requester ID tag; not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; handshake when valid&ready.
- req_in  in  N_REQ x word_t  per-requester 64b operand.
- req_mode  in  N_REQ x mode_t  per-requester lane mode.
- req_op  in  N_REQ x op_t  per-requester shift op.
- req_shift  in  N_REQ x (8 x shift_t)  per-requester per-lane shift amounts.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_out  out  word_t  shifted result.
- rsp_id  out  ID_W  index of the requester that owns rsp_out.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - s1_v=0, s2_v=0, rsp_valid=0, rsp_out=0, rsp_id=0, req_ready=0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
- Pipeline:
  - S1 (issue reg) holds {in, mode, op, shift, id}.
  - The `simd_shifter` instance is combinational on S1 contents.
  - S2 (output reg) holds {out, id}, driving rsp_*.
- Advance rules:
  - s2_adv = s1_v & (!s2_v | rsp_ready).
  - s1_free = !s1_v | s2_adv.
- Arbitration:
  - grant = one-hot round-robin over req_valid, search starting at ptr+1 and wrapping at N_REQ-1→0.
  - req_ready[i] = grant[i] & s1_free.
  - At most one req_ready is high per cycle.
  - rsp_ready→req_ready combinational path is permitted and documented.
- On request handshake of i: S1 loads requester i's payload with id=i, s1_v=1, ptr=i.
  - ptr changes only on handshake.
  - No grant means ptr holds and s1_v clears if s2_adv.
- On s2_adv: S2 loads shifter output and S1 id, s2_v=1.
  - If rsp_valid&rsp_ready and no s2_adv, s2_v=0.
  - rsp_out/rsp_id hold their value when s2_v=0.
- Latency: a request accepted at edge k gives rsp_valid from edge k+1 (S1 load) +1 = visible after edge k+1.
  - Precisely, the handshake at edge k loads S1; S2 loads at edge k+1; rsp_valid=1 in the cycle after k+1.
  - Fixed 2-edge latency when rsp_ready=1.
- Throughput: with rsp_ready held 1 and requests always valid, one handshake and one response per cycle.
- Backpressure:
  - rsp_valid, rsp_out and rsp_id stay stable while rsp_valid&!rsp_ready.
  - Maximum 2 outstanding (S1+S2); then req_ready=0 for all.
- Requester rules:
  - Payload must be stable while req_valid&!req_ready.
  - req_valid must not depend on req_ready.
  - A requester may drop req_valid before grant; no state is retained for it.
- Simultaneous events:
  - S2 drain and S1 load in the same cycle are allowed; the pipeline stays full.
  - All N_REQ valid: strict rotation 0,1,2,3,0… after reset.
- Reset mid-operation: both stages invalidate immediately and in-flight results are discarded; no response for them.
- Arithmetic/width: no arithmetic in this block; shift semantics are entirely those of `simd_shifter`.

Decomposition:
- simd_shifter_pkg: reuse word_t, mode_t, op_t, shift_t.
  - Add a typedef for the S1 payload struct (in, mode, op, shift[7:0]).
  - Add a parameterizable-free constant SIMD_SHIFTER_SCHED_N_REQ=4.
- Sub-module simd_shifter_rr_arb: N_REQ-wide round-robin grant from req vector + ptr; purely combinational with ptr held in the parent.
- `simd_shifter` instantiated unchanged.

Test Plan:
- Single request:
  - Stimulus: reset; requester 2 valid with in=64'h1, op=OP_SLL, mode=MODE_64, shift[0]=4, rsp_ready=1.
  - Response: req_ready[2]=1 one cycle; rsp_valid=1 two edges later with rsp_out=64'h10, rsp_id=2; then rsp_valid=0.
- Round-robin fairness:
  - Stimulus: all 4 valid continuously, rsp_ready=1, 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; 8 responses with rsp_id in the same order; no bubbles.
- Backpressure:
  - Stimulus: rsp_ready=0 with requesters 0,1 valid.
  - Response: exactly 2 handshakes, then req_ready=0; rsp_out/rsp_id stable.
  - Then rsp_ready=1: responses id 0 then 1 on consecutive cycles, and a third handshake in the same cycle as the first drain.
- Sparse requests:
  - Stimulus: requester 3 valid, one cycle later requester 1 valid.
  - Response: 3 granted first; ptr=3, so 1 is granted next even though 0 is idle; ids 3,1.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 asynchronously with S1 and S2 valid.
  - Response: rsp_valid=0 immediately (same cycle, no clock edge); after release, the first grant goes to requester 0 and no stale response appears.
- Random equivalence:
  - Stimulus: 10k random payloads, random req_valid/rsp_ready.
  - Response: every rsp_out matches the scoreboard model of the shifter for the matching id in per-requester order; no lost or duplicate responses.
